// File: rtl/nn_result_scorer_if.sv
// Bundle between the NN top and its result scorer: prediction stream, label ROM lookup, score status.
// Optional SCORER_FIRST_MISS_EN adds first_miss_idx / first_miss_valid.
interface nn_result_scorer_if #(
    parameter int unsigned CNT_W  = 10,
    parameter int unsigned DATA_W = 8
);
    logic              start;
    logic              result_valid;
    logic [DATA_W-1:0] result;
    logic              batch_done;
    logic              nn_done;
    logic [CNT_W-1:0]  label_addr;
    logic [DATA_W-1:0] label_in;
    logic [CNT_W-1:0]  sample_count;
    logic [CNT_W-1:0]  correct_count;
    logic [CNT_W-1:0]  batch_correct;
    logic [6:0]        accuracy_pct;
    logic              busy;
    logic              score_valid;
    logic              overrun;
`ifdef SCORER_FIRST_MISS_EN
    logic [CNT_W-1:0]  first_miss_idx;
    logic              first_miss_valid;

    modport slave (
        input  start, result_valid, result, batch_done, nn_done, label_in,
        output label_addr, sample_count, correct_count, batch_correct, accuracy_pct,
               busy, score_valid, overrun, first_miss_idx, first_miss_valid
    );
    modport master (
        output start, result_valid, result, batch_done, nn_done, label_in,
        input  label_addr, sample_count, correct_count, batch_correct, accuracy_pct,
               busy, score_valid, overrun, first_miss_idx, first_miss_valid
    );
`else
    modport slave (
        input  start, result_valid, result, batch_done, nn_done, label_in,
        output label_addr, sample_count, correct_count, batch_correct, accuracy_pct,
               busy, score_valid, overrun
    );
    modport master (
        output start, result_valid, result, batch_done, nn_done, label_in,
        input  label_addr, sample_count, correct_count, batch_correct, accuracy_pct,
               busy, score_valid, overrun
    );
`endif
endinterface

// File: rtl/nn_result_scorer.sv
// Scores NN predictions against a label ROM, per run and per batch, then divides for accuracy percent.
// Optional feature macro: SCORER_FIRST_MISS_EN (first mismatching sample index).
module nn_result_scorer #(
    parameter int unsigned N_SAMPLES = 750,
    parameter int unsigned CNT_W     = 10,
    parameter int unsigned DATA_W    = 8
) (
    input logic               clk,
    input logic               rst,
    nn_result_scorer_if.slave sif
);
    localparam int unsigned NUM_W     = CNT_W + 7;
    localparam int unsigned DIV_CNT_W = $clog2(NUM_W);
    localparam int unsigned PCT_W     = 7;

    typedef enum logic [1:0] {IDLE, RUN, DIVIDE, DONE} state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]     sample_count, correct_count, batch_acc, batch_correct;
    logic [PCT_W-1:0]     accuracy_pct;
    logic                 busy, score_valid, overrun;
    logic [NUM_W-1:0]     div_q;
    logic [CNT_W-1:0]     div_rem, div_dvsr;
    logic [DIV_CNT_W-1:0] div_cnt;

    logic                 accept, hit, run_start, div_last;
    logic [CNT_W-1:0]     sample_upd, correct_upd, rem_step;
    logic [CNT_W:0]       trial;
    logic                 trial_ge;
    logic [NUM_W-1:0]     q_step, dividend;

    // Per-cycle acceptance; updated counts feed a same-cycle nn_done
    always_comb begin
        accept      = (state == RUN) && sif.result_valid && (sample_count < CNT_W'(N_SAMPLES));
        hit         = accept && (sif.result == sif.label_in);
        run_start   = ((state == IDLE) || (state == DONE)) && sif.start;
        sample_upd  = sample_count + CNT_W'(accept);
        correct_upd = correct_count + CNT_W'(hit);
        dividend    = NUM_W'(correct_upd) * NUM_W'(100);
        div_last    = (div_cnt == DIV_CNT_W'(NUM_W - 1));
    end

    // One restoring-division step: shift in next dividend bit, subtract if it fits
    always_comb begin
        trial    = {div_rem, div_q[NUM_W-1]};
        trial_ge = (trial >= {1'b0, div_dvsr});
        rem_step = trial_ge ? CNT_W'(trial - {1'b0, div_dvsr}) : CNT_W'(trial);
        q_step   = {div_q[NUM_W-2:0], trial_ge};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (sif.start) state_nxt = RUN;
            RUN:     if (sif.nn_done) state_nxt = (sample_upd == '0) ? DONE : DIVIDE;
            DIVIDE:  if (div_last) state_nxt = DONE;
            DONE:    if (sif.start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_count  <= '0;
            correct_count <= '0;
            batch_acc     <= '0;
            batch_correct <= '0;
            accuracy_pct  <= '0;
            busy          <= 1'b0;
            score_valid   <= 1'b0;
            overrun       <= 1'b0;
            div_q         <= '0;
            div_rem       <= '0;
            div_dvsr      <= '0;
            div_cnt       <= '0;
        end else begin
            busy        <= (state_nxt == RUN) || (state_nxt == DIVIDE);
            score_valid <= (state_nxt == DONE);
            if (run_start) begin
                sample_count  <= '0;
                correct_count <= '0;
                batch_acc     <= '0;
                batch_correct <= '0;
                accuracy_pct  <= '0;
                overrun       <= 1'b0;
            end
            if (state == RUN) begin
                sample_count  <= sample_upd;
                correct_count <= correct_upd;
                if (sif.result_valid && (sample_count == CNT_W'(N_SAMPLES))) overrun <= 1'b1;
                // A hit coinciding with batch_done belongs to the closing batch
                if (sif.batch_done) begin
                    batch_correct <= batch_acc + CNT_W'(hit);
                    batch_acc     <= '0;
                end else begin
                    batch_acc     <= batch_acc + CNT_W'(hit);
                end
                if (sif.nn_done) begin
                    div_q    <= dividend;
                    div_rem  <= '0;
                    div_dvsr <= sample_upd;
                    div_cnt  <= '0;
                end
            end
            if (state == DIVIDE) begin
                div_q   <= q_step;
                div_rem <= rem_step;
                div_cnt <= div_cnt + DIV_CNT_W'(1);
                if (div_last) accuracy_pct <= q_step[PCT_W-1:0];
            end
        end
    end

`ifdef SCORER_FIRST_MISS_EN
    logic [CNT_W-1:0] first_miss_idx;
    logic             first_miss_valid;

    // Latch only the first mismatch of a run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_miss_idx   <= '0;
            first_miss_valid <= 1'b0;
        end else if (run_start) begin
            first_miss_idx   <= '0;
            first_miss_valid <= 1'b0;
        end else if (accept && !hit && !first_miss_valid) begin
            first_miss_idx   <= sample_count;
            first_miss_valid <= 1'b1;
        end
    end

    assign sif.first_miss_idx   = first_miss_idx;
    assign sif.first_miss_valid = first_miss_valid;
`endif

    assign sif.label_addr    = sample_count;
    assign sif.sample_count  = sample_count;
    assign sif.correct_count = correct_count;
    assign sif.batch_correct = batch_correct;
    assign sif.accuracy_pct  = accuracy_pct;
    assign sif.busy          = busy;
    assign sif.score_valid   = score_valid;
    assign sif.overrun       = overrun;

endmodule

// File: tb/tb_nn_result_scorer.sv
// Scoreboard bench for nn_result_scorer: directed runs push expected scores, a monitor checks each DONE.
// Optional SCORER_FIRST_MISS_EN checks are compiled in when the macro is defined.
module tb_nn_result_scorer;
    localparam int unsigned CNT_W  = 10;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned NUM_W  = CNT_W + 7;

    typedef struct {
        int sc;
        int cc;
        int pct;
        int ovr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic sv_q = 1'b0;

    nn_result_scorer_if #(.CNT_W(CNT_W), .DATA_W(DATA_W)) sif();

    nn_result_scorer #(.N_SAMPLES(750), .CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] rom(input logic [CNT_W-1:0] a);
        return DATA_W'(a % 10);
    endfunction

    assign sif.label_in = rom(sif.label_addr);

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    // Monitor: each new DONE pops one expected score
    always @(negedge clk) begin
        if (sif.score_valid && !sv_q) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_score", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("score_sample_count", int'(sif.sample_count), mon_e.sc);
                chk("score_correct_count", int'(sif.correct_count), mon_e.cc);
                chk("score_accuracy_pct", int'(sif.accuracy_pct), mon_e.pct);
                chk("score_overrun", int'(sif.overrun), mon_e.ovr);
            end
        end
        sv_q <= sif.score_valid;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        sif.start = 1'b1;
        cyc();
        sif.start = 1'b0;
    endtask

    task automatic res(input bit ok, input int idx, input bit bd);
        sif.result       = ok ? rom(CNT_W'(idx)) : DATA_W'(rom(CNT_W'(idx)) + 8'd1);
        sif.result_valid = 1'b1;
        sif.batch_done   = bd;
        cyc();
        sif.result_valid = 1'b0;
        sif.batch_done   = 1'b0;
    endtask

    // nn_done (optionally with a correct result), then count cycles until score_valid
    task automatic finish_run(input int want_lat, input int start_at, input bit with_res, input int idx);
        int n;
        if (with_res) begin
            sif.result       = rom(CNT_W'(idx));
            sif.result_valid = 1'b1;
        end
        sif.nn_done = 1'b1;
        cyc();
        sif.nn_done      = 1'b0;
        sif.result_valid = 1'b0;
        n = 1;
        while (!sif.score_valid && n < 40) begin
            if (n == start_at) sif.start = 1'b1;
            cyc();
            sif.start = 1'b0;
            n++;
            if (n == start_at + 1) begin
                chk("busy_after_start_in_divide", int'(sif.busy), 1);
                chk("no_score_after_start_in_divide", int'(sif.score_valid), 0);
            end
        end
        chk("done_latency", n, want_lat);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_sample_count"}, int'(sif.sample_count), 0);
        chk({tag, "_correct_count"}, int'(sif.correct_count), 0);
        chk({tag, "_batch_correct"}, int'(sif.batch_correct), 0);
        chk({tag, "_accuracy_pct"}, int'(sif.accuracy_pct), 0);
        chk({tag, "_busy"}, int'(sif.busy), 0);
        chk({tag, "_score_valid"}, int'(sif.score_valid), 0);
        chk({tag, "_overrun"}, int'(sif.overrun), 0);
        chk({tag, "_label_addr"}, int'(sif.label_addr), 0);
    endtask

    initial begin
        rst              = 1'b1;
        sif.start        = 1'b0;
        sif.result_valid = 1'b0;
        sif.result       = '0;
        sif.batch_done   = 1'b0;
        sif.nn_done      = 1'b0;
        repeat (2) cyc();
        chk_zero("reset");
        rst = 1'b0;
        cyc();

        // Reset mid-run aborts with no partial score
        pulse_start();
        for (int i = 0; i < 37; i++) res(1'b1, i, 1'b0);
        chk("midrun_sample_count", int'(sif.sample_count), 37);
        chk("midrun_busy", int'(sif.busy), 1);
        rst = 1'b1;
        #1;
        chk_zero("async_reset");
        cyc();
        rst = 1'b0;
        cyc();
        chk("post_reset_busy", int'(sif.busy), 0);
        chk("post_reset_idle_no_score", int'(sif.score_valid), 0);

        // 4 results, 3 correct -> 75%
        pulse_start();
        res(1'b1, 0, 1'b0);
        res(1'b1, 1, 1'b0);
        res(1'b0, 2, 1'b0);
        res(1'b1, 3, 1'b0);
        chk("run4_sample_count", int'(sif.sample_count), 4);
        chk("run4_correct_count", int'(sif.correct_count), 3);
        exp_q.push_back('{sc: 4, cc: 3, pct: 75, ovr: 0});
        finish_run(NUM_W + 1, 0, 1'b0, 0);

        // Batches; final correct result coincides with nn_done
        pulse_start();
        chk("restart_clears_samples", int'(sif.sample_count), 0);
        res(1'b1, 0, 1'b0);
        res(1'b0, 1, 1'b0);
        res(1'b0, 2, 1'b0);
        res(1'b1, 3, 1'b0);
        res(1'b1, 4, 1'b1);
        chk("batch1_correct", int'(sif.batch_correct), 3);
        res(1'b0, 5, 1'b0);
        res(1'b1, 6, 1'b0);
        res(1'b0, 7, 1'b0);
        sif.batch_done = 1'b1;
        cyc();
        sif.batch_done = 1'b0;
        chk("batch2_correct", int'(sif.batch_correct), 1);
        chk("batch_run_correct_count", int'(sif.correct_count), 4);
        exp_q.push_back('{sc: 9, cc: 5, pct: 55, ovr: 0});
        finish_run(NUM_W + 1, 0, 1'b1, 8);

        // Empty run -> immediate DONE with 0%
        pulse_start();
        chk("empty_run_busy", int'(sif.busy), 1);
        chk("empty_run_pct_cleared", int'(sif.accuracy_pct), 0);
        exp_q.push_back('{sc: 0, cc: 0, pct: 0, ovr: 0});
        finish_run(1, 0, 1'b0, 0);

        // Misses at samples 2 and 5; start in DIVIDE ignored, start in DONE restarts
        pulse_start();
        res(1'b1, 0, 1'b0);
        res(1'b1, 1, 1'b0);
        res(1'b0, 2, 1'b0);
        res(1'b1, 3, 1'b0);
        res(1'b1, 4, 1'b0);
        res(1'b0, 5, 1'b0);
`ifdef SCORER_FIRST_MISS_EN
        chk("first_miss_idx", int'(sif.first_miss_idx), 2);
        chk("first_miss_valid", int'(sif.first_miss_valid), 1);
`endif
        exp_q.push_back('{sc: 6, cc: 4, pct: 66, ovr: 0});
        finish_run(NUM_W + 1, 5, 1'b0, 0);
        cyc();
        chk("done_holds_score_valid", int'(sif.score_valid), 1);
        chk("done_holds_pct", int'(sif.accuracy_pct), 66);
        pulse_start();
        chk("done_restart_busy", int'(sif.busy), 1);
        chk("done_restart_score_valid", int'(sif.score_valid), 0);
        chk("done_restart_samples", int'(sif.sample_count), 0);
        chk("done_restart_correct", int'(sif.correct_count), 0);
        chk("done_restart_pct", int'(sif.accuracy_pct), 0);
`ifdef SCORER_FIRST_MISS_EN
        chk("done_restart_first_miss_idx", int'(sif.first_miss_idx), 0);
        chk("done_restart_first_miss_valid", int'(sif.first_miss_valid), 0);
`endif

        // Full 750-sample run, then one extra result -> overrun, 100%
        for (int i = 0; i < 750; i++) res(1'b1, i, 1'b0);
        chk("full_sample_count", int'(sif.sample_count), 750);
        chk("full_correct_count", int'(sif.correct_count), 750);
        chk("full_no_overrun_yet", int'(sif.overrun), 0);
        res(1'b1, 750, 1'b0);
        chk("overrun_sample_count", int'(sif.sample_count), 750);
        chk("overrun_label_addr", int'(sif.label_addr), 750);
        chk("overrun_flag", int'(sif.overrun), 1);
        exp_q.push_back('{sc: 750, cc: 750, pct: 100, ovr: 1});
        finish_run(NUM_W + 1, 0, 1'b0, 0);

        repeat (3) cyc();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
